// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - EX-stage branch resolution with a bimodal predictor,
// registered fetch redirect and saturating statistics.
module branch_predict_resolve #(
  parameter int          XLEN        = 32,
  parameter int          BHT_ENTRIES = 64,
  parameter int          IDX_LO      = 2,
  parameter logic [1:0]  CNT_INIT    = 2'b01,
  parameter int          STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid_i,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              pred_valid_o,
  output logic              pred_taken_o,
  input  logic              ex_valid_i,
  input  logic              ex_branch_en_i,
  input  logic [2:0]        ex_func3_i,
  input  logic [3:0]        ex_alu_flags_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic [XLEN-1:0]   ex_target_i,
  input  logic              ex_pred_taken_i,
  output logic              branch_taken_o,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [STAT_W-1:0] stat_branch_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  logic [1:0]        r_bht [BHT_ENTRIES];
  logic              r_pred_valid;
  logic              r_pred_taken;
  logic              r_mis;
  logic [XLEN-1:0]   r_redirect;
  logic [STAT_W-1:0] r_stat_br;
  logic [STAT_W-1:0] r_stat_mis;

  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic              w_resolve;
  logic              w_legal;
  logic              w_cond;
  logic              w_taken;
  logic              w_train;
  logic              w_mis;
  logic [1:0]        w_ex_cnt;
  logic [1:0]        w_cnt_next;
  logic              w_zf, w_sf, w_cf, w_of;
  logic              w_unused;

  assign w_if_idx  = if_pc_i[IDX_LO +: IDX_W];
  assign w_ex_idx  = ex_pc_i[IDX_LO +: IDX_W];
  assign w_unused  = ^{if_pc_i, ex_pc_i};

  assign w_zf = ex_alu_flags_i[0];
  assign w_sf = ex_alu_flags_i[1];
  assign w_cf = ex_alu_flags_i[2];
  assign w_of = ex_alu_flags_i[3];

  // CF=1 means no borrow, so unsigned less-than is !CF
  always_comb begin
    w_legal = 1'b1;
    w_cond  = 1'b0;
    case (ex_func3_i)
      3'b000:  w_cond = w_zf;
      3'b001:  w_cond = ~w_zf;
      3'b100:  w_cond = w_sf ^ w_of;
      3'b101:  w_cond = ~(w_sf ^ w_of);
      3'b110:  w_cond = ~w_cf;
      3'b111:  w_cond = w_cf;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_resolve      = ex_valid_i & ex_branch_en_i;
  assign w_taken        = w_resolve & w_legal & w_cond;
  assign w_train        = w_resolve & w_legal;
  assign w_mis          = w_resolve & (w_taken != ex_pred_taken_i);
  assign branch_taken_o = w_taken;

  assign w_ex_cnt = r_bht[w_ex_idx];

  always_comb begin
    w_cnt_next = w_ex_cnt;
    if (w_taken) begin
      if (w_ex_cnt != 2'b11) w_cnt_next = w_ex_cnt + 2'd1;
    end else begin
      if (w_ex_cnt != 2'b00) w_cnt_next = w_ex_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CNT_INIT;
    end else if (w_train) begin
      r_bht[w_ex_idx] <= w_cnt_next;
    end
  end

  // Lookup samples the table before this edge's training write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      r_pred_valid <= if_valid_i;
      if (if_valid_i) r_pred_taken <= r_bht[w_if_idx][1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis      <= 1'b0;
      r_redirect <= '0;
    end else begin
      r_mis <= w_mis;
      if (w_mis) r_redirect <= w_taken ? ex_target_i : ex_pc_i + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else begin
      if (w_train && (r_stat_br != '1))  r_stat_br  <= r_stat_br + STAT_W'(1);
      if (w_mis && (r_stat_mis != '1))   r_stat_mis <= r_stat_mis + STAT_W'(1);
    end
  end

  assign pred_valid_o   = r_pred_valid;
  assign pred_taken_o   = r_pred_taken;
  assign mispredict_o   = r_mis;
  assign redirect_pc_o  = r_redirect;
  assign stat_branch_o  = r_stat_br;
  assign stat_mispred_o = r_stat_mis;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb/tb_branch_predict_resolve.sv - scoreboard bench for branch_predict_resolve
// (default instance plus a STAT_W=2 instance for saturation).
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic        ex_valid = 1'b0;
  logic        ex_branch_en = 1'b0;
  logic [2:0]  ex_func3 = '0;
  logic [3:0]  ex_flags = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        ex_pred = 1'b0;

  logic        d1_pred_valid, d1_pred_taken, d1_taken, d1_mis;
  logic [31:0] d1_redirect;
  logic [15:0] d1_stat_br, d1_stat_mis;
  logic        d2_pred_valid, d2_pred_taken, d2_taken, d2_mis;
  logic [31:0] d2_redirect;
  logic [1:0]  d2_stat_br, d2_stat_mis;

  int checks = 0;
  int failures = 0;
  int exp_br = 0;
  int exp_mis = 0;
  logic        pq[$];
  logic [31:0] rq[$];

  always #5 clk = ~clk;

  branch_predict_resolve dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid), .if_pc_i(if_pc),
    .pred_valid_o(d1_pred_valid), .pred_taken_o(d1_pred_taken),
    .ex_valid_i(ex_valid), .ex_branch_en_i(ex_branch_en), .ex_func3_i(ex_func3),
    .ex_alu_flags_i(ex_flags), .ex_pc_i(ex_pc), .ex_target_i(ex_target),
    .ex_pred_taken_i(ex_pred), .branch_taken_o(d1_taken), .mispredict_o(d1_mis),
    .redirect_pc_o(d1_redirect), .stat_branch_o(d1_stat_br), .stat_mispred_o(d1_stat_mis)
  );

  branch_predict_resolve #(.STAT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid), .if_pc_i(if_pc),
    .pred_valid_o(d2_pred_valid), .pred_taken_o(d2_pred_taken),
    .ex_valid_i(ex_valid), .ex_branch_en_i(ex_branch_en), .ex_func3_i(ex_func3),
    .ex_alu_flags_i(ex_flags), .ex_pc_i(ex_pc), .ex_target_i(ex_target),
    .ex_pred_taken_i(ex_pred), .branch_taken_o(d2_taken), .mispredict_o(d2_mis),
    .redirect_pc_o(d2_redirect), .stat_branch_o(d2_stat_br), .stat_mispred_o(d2_stat_mis)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if_valid = 1'b0;
    ex_valid = 1'b0;
    ex_branch_en = 1'b0;
    ex_pred = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp);
    if_valid = 1'b1;
    if_pc = pc;
    pq.push_back(exp);
  endtask

  task automatic br(input string name, input logic en, input logic [2:0] f3, input logic [3:0] fl,
                    input logic [31:0] pc, input logic [31:0] tgt, input logic pred, input logic exp_taken);
    ex_valid = 1'b1;
    ex_branch_en = en;
    ex_func3 = f3;
    ex_flags = fl;
    ex_pc = pc;
    ex_target = tgt;
    ex_pred = pred;
    #1;
    check(name, {31'd0, d1_taken}, {31'd0, exp_taken});
    if (en && f3 != 3'b010 && f3 != 3'b011) exp_br++;
    if (en && exp_taken != pred) begin
      exp_mis++;
      rq.push_back(exp_taken ? tgt : pc + 32'd4);
    end
  endtask

  task automatic chk_stats(input string name);
    check({name, "_stat_br"}, {16'd0, d1_stat_br}, exp_br);
    check({name, "_stat_mis"}, {16'd0, d1_stat_mis}, exp_mis);
  endtask

  // Monitor: registered outputs are popped against the scoreboard on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (d1_pred_valid) begin
        if (pq.size() == 0) check("pred_unexpected", 32'd1, 32'd0);
        else check("pred_taken", {31'd0, d1_pred_taken}, {31'd0, pq.pop_front()});
      end
      if (d1_mis) begin
        if (rq.size() == 0) check("mis_unexpected", 32'd1, 32'd0);
        else check("redirect_pc", d1_redirect, rq.pop_front());
      end
    end
  end

  initial begin
    cyc();
    cyc();
    check("rst_pred_valid", {31'd0, d1_pred_valid}, 32'd0);
    check("rst_mis", {31'd0, d1_mis}, 32'd0);
    check("rst_redirect", d1_redirect, 32'd0);
    chk_stats("rst");
    rst_n = 1'b1;

    // 1: initial lookup is weakly not-taken
    cyc();
    lookup(32'h100, 1'b0);
    cyc();
    cyc();
    check("t1_mis", {31'd0, d1_mis}, 32'd0);
    chk_stats("t1");

    // 2: BEQ training at 0x100 saturates at 11, then decays
    br("t2_beq0", 1'b1, 3'b000, 4'b0001, 32'h100, 32'h80, 1'b0, 1'b1);
    cyc();
    br("t2_beq1", 1'b1, 3'b000, 4'b0001, 32'h100, 32'h80, 1'b1, 1'b1);
    cyc();
    br("t2_beq2", 1'b1, 3'b000, 4'b0001, 32'h100, 32'h80, 1'b1, 1'b1);
    cyc();
    lookup(32'h100, 1'b1);
    cyc();
    br("t2_nt0", 1'b1, 3'b000, 4'b0000, 32'h100, 32'h80, 1'b0, 1'b0);
    cyc();
    lookup(32'h100, 1'b1);
    cyc();
    br("t2_nt1", 1'b1, 3'b000, 4'b0000, 32'h100, 32'h80, 1'b0, 1'b0);
    cyc();
    lookup(32'h100, 1'b0);
    cyc();
    chk_stats("t2");

    // 3: signed/unsigned compares with correct predictions, plus ungated branch
    br("t3_blt_t", 1'b1, 3'b100, 4'b0010, 32'h204, 32'h300, 1'b1, 1'b1);
    cyc();
    br("t3_blt_nt", 1'b1, 3'b100, 4'b1010, 32'h208, 32'h300, 1'b0, 1'b0);
    cyc();
    br("t3_bltu_nt", 1'b1, 3'b110, 4'b0100, 32'h20C, 32'h300, 1'b0, 1'b0);
    cyc();
    br("t3_bgeu_t", 1'b1, 3'b111, 4'b0100, 32'h210, 32'h300, 1'b1, 1'b1);
    cyc();
    br("t3_bge_t", 1'b1, 3'b101, 4'b1010, 32'h214, 32'h300, 1'b1, 1'b1);
    cyc();
    br("t3_bne_t", 1'b1, 3'b001, 4'b0000, 32'h218, 32'h300, 1'b1, 1'b1);
    cyc();
    br("t3_not_branch", 1'b0, 3'b000, 4'b0001, 32'h21C, 32'h300, 1'b0, 1'b0);
    cyc();
    check("t3_mis", {31'd0, d1_mis}, 32'd0);
    chk_stats("t3");

    // 4: not-taken redirect wraps past the top of the address space
    br("t4_bne", 1'b1, 3'b001, 4'b0001, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0);
    cyc();
    cyc();

    // 5: read-before-write, then illegal func3 leaves table and branch count alone
    lookup(32'h100, 1'b0);
    br("t5_beq", 1'b1, 3'b000, 4'b0001, 32'h100, 32'h80, 1'b0, 1'b1);
    cyc();
    br("t5_illegal", 1'b1, 3'b010, 4'b0001, 32'h100, 32'h80, 1'b1, 1'b0);
    cyc();
    lookup(32'h100, 1'b1);
    cyc();
    cyc();
    chk_stats("t5");

    // 6: reset while a redirect is showing, then saturate the 2-bit stats
    br("t6_beq", 1'b1, 3'b000, 4'b0001, 32'h300, 32'h40, 1'b0, 1'b1);
    cyc();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_mis", {31'd0, d1_mis}, 32'd0);
    check("t6_rst_redirect", d1_redirect, 32'd0);
    exp_br = 0;
    exp_mis = 0;
    chk_stats("t6_rst");
    cyc();
    rst_n = 1'b1;
    lookup(32'h100, 1'b0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      br("t6_burst", 1'b1, 3'b000, 4'b0001, 32'h400 + 32'(i * 4), 32'h1000 + 32'(i * 4), 1'b0, 1'b1);
      cyc();
    end
    cyc();
    chk_stats("t6");
    check("t6_sat_br", {30'd0, d2_stat_br}, 32'd3);
    check("t6_sat_mis", {30'd0, d2_stat_mis}, 32'd3);

    cyc();
    cyc();
    check("pred_queue_drained", pq.size(), 32'd0);
    check("redirect_queue_drained", rq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
